// File: rtl/cordic_pkg.sv
// cordic_pkg
//   Shared definitions for the rotation-mode CORDIC engine and its
//   arctangent ROM: datapath widths, gain pre-compensation constant,
//   FSM state type and the fixed-point to output conversion helper.
//
//   Build option: CORDIC_ROUND_EN
//     defined   -> output conversion rounds half up (adds half an LSB
//                  before dropping the fraction bits)
//     undefined -> output conversion truncates toward minus infinity
//   Saturation to [-127, +127] applies in both builds.
package cordic_pkg;

  localparam int ANGLE_W   = 10;  // integer degrees, 0..359 legal
  localparam int MAG_W     = 7;   // unsigned magnitude
  localparam int Z_W       = 16;  // residual angle, signed degrees Q9.6
  localparam int Z_FRAC    = 6;
  localparam int XY_W      = 14;  // x/y accumulators, signed Q9.4
  localparam int XY_FRAC   = 4;
  localparam int OUT_W     = 8;   // signed integer outputs
  localparam int CNT_W     = 4;   // micro-rotation index
  localparam int GAIN_COMP = 155; // 155/256 ~= 1/1.6468 (CORDIC gain)

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_ITER,
    ST_DONE
  } state_t;

  // Q9.4 accumulator -> signed integer, clamped symmetric so -128 never
  // appears on the output.
  function automatic logic signed [OUT_W-1:0] xy_to_out(
    input logic signed [XY_W-1:0] v
  );
    logic signed [XY_W:0] ext;
    logic signed [XY_W:0] ext_sh;
    ext = {v[XY_W-1], v};
`ifdef CORDIC_ROUND_EN
    ext = ext + (XY_W+1)'(signed'(1 <<< (XY_FRAC - 1)));
`else
    ext = ext;
`endif
    ext_sh = ext >>> XY_FRAC;
    if (ext_sh > (XY_W+1)'(signed'(127))) begin
      return OUT_W'(signed'(127));
    end else if (ext_sh < (XY_W+1)'(signed'(-127))) begin
      return OUT_W'(signed'(-127));
    end else begin
      return ext_sh[OUT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// cordic_atan_lut
//   Combinational arctangent ROM shared by the rotation and vectoring
//   CORDIC engines. Entry i holds atan(2^-i) in degrees, Q9.6, rounded
//   to nearest.
//
//   Ports:
//     idx   in  4   micro-rotation index
//     atan  out 16  atan(2^-idx), unsigned degrees Q9.6
module cordic_atan_lut
  import cordic_pkg::*;
(
  input  logic [CNT_W-1:0] idx,
  output logic [Z_W-1:0]   atan
);

  always_comb begin
    atan = '0;
    case (idx)
      4'd0:    atan = 16'd2880;
      4'd1:    atan = 16'd1700;
      4'd2:    atan = 16'd898;
      4'd3:    atan = 16'd456;
      4'd4:    atan = 16'd229;
      4'd5:    atan = 16'd115;
      4'd6:    atan = 16'd57;
      4'd7:    atan = 16'd29;
      4'd8:    atan = 16'd14;
      4'd9:    atan = 16'd7;
      4'd10:   atan = 16'd4;
      4'd11:   atan = 16'd2;
      4'd12:   atan = 16'd1;
      default: atan = 16'd0;  // below Q9.6 resolution from here on
    endcase
  end

endmodule

// File: rtl/cordic_rotate.sv
// cordic_rotate
//   Rotation-mode CORDIC: converts (magnitude, integer-degree angle) into
//   (r*cos, r*sin), one micro-rotation per clock. Latency from the start
//   sampling edge to result_vld is ITERATIONS+2 cycles.
//
//   Build option: CORDIC_ROUND_EN (see cordic_pkg) selects round-half-up
//   instead of truncation on the outputs.
//
//   Parameters:
//     ITERATIONS  number of micro-rotations, 4..16
//   Ports:
//     clk         in   1   clock
//     rst_n       in   1   asynchronous active-low reset
//     start       in   1   request, sampled only while idle
//     angle_in    in   10  unsigned degrees, 0..359 legal
//     mag_in      in   7   unsigned magnitude
//     busy        out  1   request in flight
//     result_vld  out  1   one-cycle pulse, x_out/y_out updated
//     x_out       out  8   signed r*cos(theta), held until next result
//     y_out       out  8   signed r*sin(theta), held until next result
//     err         out  1   one-cycle pulse for a start with angle >= 360
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on a legal request
//   INIT  | gain pre-compensation and quadrant fold into +/-90 degrees
//   ITER  | one micro-rotation per cycle, index 0..ITERATIONS-1
//   DONE  | convert/saturate accumulators into the output registers
module cordic_rotate
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ANGLE_W-1:0]       angle_in,
  input  logic [MAG_W-1:0]         mag_in,
  output logic                     busy,
  output logic                     result_vld,
  output logic signed [OUT_W-1:0]  x_out,
  output logic signed [OUT_W-1:0]  y_out,
  output logic                     err
);

  state_t state, state_next;

  logic [ANGLE_W-1:0]     angle_q;
  logic [MAG_W-1:0]       mag_q;
  logic signed [XY_W-1:0] x, y;
  logic signed [Z_W-1:0]  z;
  logic [CNT_W-1:0]       iter;

  logic                   angle_ok;
  logic                   last_iter;
  logic [14:0]            gain_prod;
  logic signed [XY_W-1:0] x_mag;
  logic signed [XY_W-1:0] x0;
  logic signed [Z_W-1:0]  z_deg;
  logic signed [Z_W-1:0]  z0;
  logic [Z_W-1:0]         atan;
  logic signed [XY_W-1:0] x_sh, y_sh;
  logic signed [XY_W-1:0] x_nxt, y_nxt;
  logic signed [Z_W-1:0]  z_nxt;

  assign angle_ok  = (angle_in < ANGLE_W'(360));
  assign last_iter = (iter == CNT_W'(ITERATIONS - 1));
  assign busy      = (state != ST_IDLE);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start && angle_ok) state_next = ST_INIT;
      ST_INIT: state_next = ST_ITER;
      ST_ITER: if (last_iter) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Initial vector: magnitude pre-scaled by 1/K so the rotation gain
  // cancels; angles outside +/-90 are folded by negating x and
  // offsetting z by 180 (or wrapping by 360 in the fourth quadrant).
  always_comb begin
    gain_prod = 15'(mag_q) * 15'(GAIN_COMP);
    x_mag     = XY_W'(gain_prod >> (8 - XY_FRAC));
    x0        = x_mag;
    z_deg     = Z_W'(angle_q);
    if (angle_q < ANGLE_W'(90)) begin
      x0    = x_mag;
      z_deg = Z_W'(angle_q);
    end else if (angle_q < ANGLE_W'(270)) begin
      x0    = -x_mag;
      z_deg = Z_W'(angle_q) - Z_W'(180);
    end else begin
      x0    = x_mag;
      z_deg = Z_W'(angle_q) - Z_W'(360);
    end
    z0 = z_deg <<< Z_FRAC;
  end

  cordic_atan_lut u_atan_lut (
    .idx  (iter),
    .atan (atan)
  );

  // One micro-rotation, direction chosen to drive z toward zero.
  always_comb begin
    x_sh = x >>> iter;
    y_sh = y >>> iter;
    if (!z[Z_W-1]) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - $signed(atan);
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + $signed(atan);
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle_q    <= '0;
      mag_q      <= '0;
      x          <= '0;
      y          <= '0;
      z          <= '0;
      iter       <= '0;
      result_vld <= 1'b0;
      err        <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
    end else begin
      result_vld <= 1'b0;
      err        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (angle_ok) begin
              angle_q <= angle_in;
              mag_q   <= mag_in;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_INIT: begin
          x    <= x0;
          y    <= '0;
          z    <= z0;
          iter <= '0;
        end
        ST_ITER: begin
          x    <= x_nxt;
          y    <= y_nxt;
          z    <= z_nxt;
          iter <= iter + CNT_W'(1);
        end
        ST_DONE: begin
          x_out      <= xy_to_out(x);
          y_out      <= xy_to_out(y);
          result_vld <= 1'b1;
          iter       <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cordic_rotate.md
# cordic_rotate

Rotation-mode CORDIC engine. It is the inverse of the vectoring-mode angle engine: it takes a magnitude and an integer-degree angle and produces the Cartesian pair (r·cos θ, r·sin θ). It iterates one micro-rotation per clock using an internal arctangent ROM. It sits beside the vectoring engine so the datapath can regenerate x/y coordinates from stored angles.

## Interface
- ITERATIONS, 12, number of micro-rotations; legal range 4–16.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- angle_in  in  10  unsigned integer degrees; legal 0–359.
- mag_in  in  7  unsigned magnitude r, 0–127.
- busy  out  1  high while a request is in flight.
- result_vld  out  1  one-cycle pulse; x_out/y_out valid.
- x_out  out  8  signed r·cos θ.
- y_out  out  8  signed r·sin θ.
- err  out  1  one-cycle pulse when start is sampled with angle_in ≥ 360.

## Operation
- FSM states: IDLE, INIT, ITER, DONE.
- IDLE, start=1, angle_in<360: capture angle_in/mag_in; go to INIT; busy=1.
- IDLE, start=1, angle_in≥360: pulse err the next cycle; stay in IDLE; no result.
- INIT, gain pre-compensation: x0 = (r·155)>>4, internal 14-bit signed Q9.4 (155/256 ≈ 1/1.6468); y0 = 0.
- INIT, quadrant pre-rotation on z, signed 16-bit, degrees Q9.6:
  - θ<90: z0 = θ.
  - 90≤θ<270: x0 negated; z0 = θ−180.
  - θ≥270: z0 = θ−360.
- ITER, step i from 0 to ITERATIONS−1, with d = +1 if z≥0 else −1:
  - x' = x − d·(y>>>i)
  - y' = y + d·(x>>>i)
  - z' = z − d·atan_lut(i)
  - Shifts are arithmetic. The iteration counter is internal.
- DONE: register outputs; pulse result_vld; return to IDLE.
- Output conversion: drop 4 fraction bits with the rounding rule from Configuration, then saturate to [−127, +127]. −128 is never produced.
- start in any state other than IDLE is ignored and not queued.
- x_out/y_out hold their last result until the next DONE.

## Timing
- Reset values: busy=0, result_vld=0, err=0, x_out=0, y_out=0, FSM=IDLE, counter=0.
- start is sampled at edge 0. INIT occupies edge 1. ITER occupies edges 2 through ITERATIONS+1. result_vld is high in the cycle after edge ITERATIONS+2.
- Total latency is ITERATIONS+2 cycles (14 at the default).
- busy rises the cycle after start is sampled and falls together with the result_vld pulse.
- Back-to-back: a new start may be sampled in the cycle in which result_vld is high.
- Reset mid-operation: all state clears immediately, no result_vld is produced, and the next start behaves normally.

## Configuration
- CORDIC_ROUND_EN defined: the output conversion adds 8 (half LSB) before the >>>4 (round half up).
- CORDIC_ROUND_EN undefined: plain arithmetic >>>4 (truncation toward −∞).
- Saturation applies in both builds.

## Structure
- Shared package cordic_pkg holds:
  - ANGLE_W = 10, Z_W = 16, Z_FRAC = 6, XY_W = 14, XY_FRAC = 4.
  - GAIN_COMP = 155.
  - The FSM state enum (typedef).
- Sub-module cordic_atan_lut is a combinational ROM: 4-bit index to 16-bit atan(2^−i) in degrees Q9.6 (entry 0 = 2880, entry 1 = 1700, …). The vectoring engine's lookup reuses the same sub-module.

## Test plan
- r=100, θ=0 → result_vld at cycle 14; x_out=100±1, y_out=0±1.
- r=100, θ=90 → x_out=0±1, y_out=100±1. r=100, θ=225 → x_out=−71±1, y_out=−71±1.
- r=127, θ=180 → x_out=−127, y_out=0±1; no wrap to +127 (saturation path).
- θ=360 with start → err pulses once, busy stays 0, no result_vld, outputs unchanged.
- start at θ=30, then start at θ=60 five cycles later → only the θ=30 result (x=87±1, y=50±1) appears, at cycle 14.
- rst_n low at ITER step 5 → all outputs 0 within the reset cycle, no result_vld; a following start at θ=45, r=64 gives x=y=45±1.
